// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one command byte to a PS/2 device: inhibits the bus, issues a
// request-to-send, shifts out 8 data bits (LSB first), odd parity and the
// stop bit on falling device clocks, then checks the device ACK.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   wr       write strobe; byte accepted only when busy=0
//   din      command byte
//   busy     transfer in progress (also 1 while rst is asserted)
//   done     one-cycle pulse: byte sent and ACK received
//   err      one-cycle pulse: NACK or timeout
//   ps2c_i   PS/2 clock pad input (asynchronous)
//   ps2d_i   PS/2 data pad input (asynchronous)
//   ps2c_oe  1 = pull PS/2 clock low
//   ps2d_oe  1 = pull PS/2 data low
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int FW = $clog2(FILTER_LEN) + 1;

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_DATA = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  // ------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer, then a debounce that only
  // moves the filtered level after FILTER_LEN consecutive differing
  // samples.
  // ------------------------------------------------------------------
  logic [1:0]    c_sync;
  logic [1:0]    d_sync;
  logic          c_filt;
  logic          d_filt;
  logic [FW-1:0] c_cnt;
  logic [FW-1:0] d_cnt;
  logic          fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      c_filt <= 1'b1;
      d_filt <= 1'b1;
      c_cnt  <= '0;
      d_cnt  <= '0;
      fall   <= 1'b0;
    end else begin
      c_sync <= {c_sync[0], ps2c_i};
      d_sync <= {d_sync[0], ps2d_i};
      fall   <= 1'b0;

      if (c_sync[1] != c_filt) begin
        if (c_cnt == FLT_LAST) begin
          c_filt <= c_sync[1];
          c_cnt  <= '0;
          // Filtered clock leaving 1 means it is going to 0.
          fall   <= c_filt;
        end else begin
          c_cnt <= c_cnt + FW'(1);
        end
      end else begin
        c_cnt <= '0;
      end

      if (d_sync[1] != d_filt) begin
        if (d_cnt == FLT_LAST) begin
          d_filt <= d_sync[1];
          d_cnt  <= '0;
        end else begin
          d_cnt <= d_cnt + FW'(1);
        end
      end else begin
        d_cnt <= '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Transfer FSM
  // ------------------------------------------------------------------
  state_t        state;
  logic [7:0]    sh;
  logic          par;
  logic [3:0]    bitcnt;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic          ack_ok;
  logic          timeout;

  assign busy    = rst | (state != IDLE);
  assign timeout = (tcnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      par     <= 1'b0;
      bitcnt  <= '0;
      icnt    <= '0;
      tcnt    <= '0;
      ack_ok  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          if (wr && !busy) begin
            sh      <= din;
            par     <= ~^din;
            ack_ok  <= 1'b0;
            icnt    <= '0;
            ps2c_oe <= 1'b1;
            state   <= INHIBIT;
          end
        end

        INHIBIT: begin
          icnt <= icnt + IW'(1);
          // Start bit goes low during the last inhibit cycle so the
          // request-to-send is in place when the clock is released.
          if (icnt == INH_DATA) begin
            ps2d_oe <= 1'b1;
          end
          if (icnt == INH_LAST) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            bitcnt  <= '0;
            tcnt    <= '0;
            state   <= SEND;
          end
        end

        SEND: begin
          if (timeout) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (fall) begin
              if (bitcnt < 4'd8) begin
                ps2d_oe <= ~sh[bitcnt[2:0]];
              end else if (bitcnt == 4'd8) begin
                ps2d_oe <= ~par;
              end else begin
                ps2d_oe <= 1'b0;
                state   <= ACK;
              end
              bitcnt <= bitcnt + 4'd1;
            end
          end
        end

        ACK: begin
          if (timeout) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (fall) begin
              if (!d_filt) begin
                ack_ok <= 1'b1;
                state  <= WAIT_IDLE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end

        WAIT_IDLE: begin
          if (timeout) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (c_filt && d_filt) begin
              done  <= ack_ok;
              state <= IDLE;
            end
          end
        end

        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - testbench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int TMO = 3000;
  localparam int FL  = 8;
  localparam int H   = 30;

  localparam int M_ACK    = 0;
  localparam int M_NOACK  = 1;
  localparam int M_WR     = 2;
  localparam int M_GLITCH = 3;
  localparam int M_RST    = 4;
  localparam int M_TMO    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, done, err, ps2c_oe, ps2d_oe;
  logic       ps2c_i, ps2d_i;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       c_glitch  = 1'b0;

  assign ps2c_i = ~(ps2c_oe | dev_c_low | c_glitch);
  assign ps2d_i = ~(ps2d_oe | dev_d_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .ps2c_i (ps2c_i),
    .ps2d_i (ps2d_i),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt, err_cnt, both_cnt, done_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (done && busy) done_busy++;
  endtask

  // Frame the device should see: data LSB first, odd parity, stop bit high.
  function automatic logic [9:0] frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic run_device(input int mode, output logic [9:0] got);
    logic aborted;
    aborted = 1'b0;
    got = '0;
    for (int i = 0; i < 11 && !aborted; i++) begin
      dev_c_low = 1'b1;
      for (int t = 0; t < H; t++) tick();
      dev_c_low = 1'b0;
      for (int t = 0; t < H && !aborted; t++) begin
        tick();
        if (t == 0 && i < 10) got[i] = ps2d_i;
        c_glitch = (mode == M_GLITCH && i == 2 && (t == 5 || (t >= 12 && t < 12 + FL - 1)));
        if (mode == M_WR && i == 3 && t == 4) begin
          din = 8'h55;
          wr  = 1'b1;
        end else begin
          wr = 1'b0;
        end
        if (mode == M_RST && i == 3 && t == 10) begin
          rst = 1'b1;
          tick();
          check("rst_busy_high", busy, 1);
          check("rst_c_oe", ps2c_oe, 0);
          check("rst_d_oe", ps2d_oe, 0);
          rst = 1'b0;
          tick();
          check("rst_busy_after", busy, 0);
          check("rst_c_oe_after", ps2c_oe, 0);
          check("rst_d_oe_after", ps2d_oe, 0);
          aborted = 1'b1;
        end
      end
      if (i == 9 && mode != M_NOACK) dev_d_low = 1'b1;
    end
    dev_d_low = 1'b0;
    dev_c_low = 1'b0;
    c_glitch  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int mode, output logic [9:0] got);
    int n;
    int d_hi;
    done_cnt  = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    done_busy = 0;
    got = '0;
    din = b;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
    n = 0;
    while (!ps2c_oe && n < 5) begin tick(); n++; end
    n = 0;
    d_hi = 0;
    while (ps2c_oe && n < INH + 50) begin
      n++;
      if (ps2d_oe) d_hi++;
      tick();
    end
    check("inhibit_len", n, INH);
    check("inhibit_data_cycles", d_hi, 1);
    check("start_bit_held", ps2d_oe, 1);
    if (mode == M_TMO) begin
      n = 0;
      while (!err && n < TMO + 100) begin tick(); n++; end
      check("timeout_latency", n, TMO);
      check("timeout_c_oe", ps2c_oe, 0);
      check("timeout_d_oe", ps2d_oe, 0);
      check("timeout_busy", busy, 0);
      tick();
      check("timeout_err_width", err_cnt, 1);
    end else begin
      repeat (20) tick();
      run_device(mode, got);
      if (mode != M_RST) begin
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        check("returned_idle", busy, 0);
        repeat (3) tick();
      end
    end
  endtask

  task automatic expect_ok(input string tag, input logic [9:0] got, input logic [7:0] b);
    check({tag, "_frame"}, got, frame(b));
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_both"}, both_cnt, 0);
    check({tag, "_done_busy"}, done_busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] got;
    logic [7:0] b;
    int busy_cycles;

    repeat (5) tick();
    check("busy_in_reset", busy, 1);
    rst = 1'b0;
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_c_oe", ps2c_oe, 0);
    check("reset_d_oe", ps2d_oe, 0);

    send(8'hED, M_ACK, got);
    expect_ok("ed", got, 8'hED);
    check("ed_parity", got[8], 1);

    send(8'hF4, M_ACK, got);
    expect_ok("f4", got, 8'hF4);
    check("f4_parity", got[8], 0);
    check("f4_stop", got[9], 1);

    send(8'h00, M_ACK, got);
    expect_ok("00", got, 8'h00);
    check("00_parity", got[8], 1);

    b = 8'($urandom);
    send(b, M_NOACK, got);
    check("nack_frame", got, frame(b));
    check("nack_err", err_cnt, 1);
    check("nack_done", done_cnt, 0);

    send(8'($urandom), M_TMO, got);
    check("timeout_done", done_cnt, 0);
    repeat (30) tick();

    send(8'hED, M_WR, got);
    expect_ok("wr_busy", got, 8'hED);
    busy_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy || ps2c_oe) busy_cycles++;
    end
    check("no_second_transfer", busy_cycles, 0);

    b = 8'($urandom);
    send(b, M_GLITCH, got);
    expect_ok("glitch", got, b);

    send(8'hED, M_RST, got);
    check("rst_no_done", done_cnt, 0);
    check("rst_no_err", err_cnt, 0);
    repeat (40) tick();

    send(8'hFF, M_ACK, got);
    expect_ok("ff", got, 8'hFF);
    check("ff_parity", got[8], 1);

    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      send(b, M_ACK, got);
      expect_ok("rand", got, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
